// File: rtl/cpu_reset_ctrl.sv
// CPU reset sequencer: HOLD -> (REL_RF) -> RUN -> DONE with staggered rf/pc release and a saturating run counter.
// Define CPU_RESET_CTRL_WATCHDOG_EN to add the RUN_CYCLES watchdog and the timeout_o port.
module cpu_reset_ctrl #(
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned STAGGER      = 0,
  parameter int unsigned RUN_CYCLES   = 29,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             sys_reset_i,
  input  logic             restart_req_i,
  input  logic             halt_i,
  output logic             pc_reset_o,
  output logic             rf_reset_o,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_count_o
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
  ,
  output logic             timeout_o
`endif
);

  localparam int unsigned HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]    STAG_LAST = SW'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_HOLD, S_REL_RF, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [HW-1:0]    hold_q;
  logic [SW-1:0]    stag_q;
  logic             pc_reset_q;
  logic             rf_reset_q;
  logic             running_q;
  logic             done_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] cycle_count_d;
  logic             rehold_d;
  logic             wd_expire_d;
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
  logic             timeout_q;
`endif

  always_comb begin
    cycle_count_d = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    // restart_req only matters once the CPU has been released
    rehold_d = sys_reset_i ||
               (restart_req_i && ((state_q == S_RUN) || (state_q == S_DONE)));
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
    wd_expire_d = (32'(cycle_count_q) == RUN_CYCLES - 1);
`else
    wd_expire_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rehold_d) begin
      state_q       <= S_HOLD;
      hold_q        <= '0;
      stag_q        <= '0;
      pc_reset_q    <= 1'b1;
      rf_reset_q    <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      cycle_count_q <= '0;
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            hold_q     <= '0;
            rf_reset_q <= 1'b0;
            if (STAGGER > 0) begin
              state_q <= S_REL_RF;
            end else begin
              state_q       <= S_RUN;
              pc_reset_q    <= 1'b0;
              running_q     <= 1'b1;
              cycle_count_q <= '0;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        S_REL_RF: begin
          if (stag_q == STAG_LAST) begin
            stag_q        <= '0;
            state_q       <= S_RUN;
            pc_reset_q    <= 1'b0;
            running_q     <= 1'b1;
            cycle_count_q <= '0;
          end else begin
            stag_q <= stag_q + SW'(1);
          end
        end
        S_RUN: begin
          if (halt_i || wd_expire_d) begin
            state_q   <= S_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
            timeout_q <= !halt_i;
`endif
          end else begin
            cycle_count_q <= cycle_count_d;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q    <= S_HOLD;
          pc_reset_q <= 1'b1;
          rf_reset_q <= 1'b1;
          running_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_reset_o    = pc_reset_q;
  assign rf_reset_o    = rf_reset_q;
  assign running_o     = running_q;
  assign done_o        = done_q;
  assign cycle_count_o = cycle_count_q;
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
  assign timeout_o     = timeout_q;
`endif

endmodule

// File: tb/tb_cpu_reset_ctrl.sv
// Directed bench for cpu_reset_ctrl: default, staggered and narrow-counter instances.
module tb_cpu_reset_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // dut0: defaults
  logic sr0 = 1'b1, rq0 = 1'b0, h0 = 1'b0;
  logic pc0, rf0, run0, dn0;
  logic [15:0] cnt0;
  // dut1: RESET_CYCLES=3, STAGGER=2
  logic sr1 = 1'b1, rq1 = 1'b0, h1 = 1'b0;
  logic pc1, rf1, run1, dn1;
  logic [15:0] cnt1;
  // dut2: CNT_W=4, watchdog budget out of reach
  logic sr2 = 1'b1, rq2 = 1'b0, h2 = 1'b0;
  logic pc2, rf2, run2, dn2;
  logic [3:0] cnt2;
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
  logic to0, to1, to2;
`endif

  cpu_reset_ctrl u_dut0 (
    .clk_i(clk), .sys_reset_i(sr0), .restart_req_i(rq0), .halt_i(h0),
    .pc_reset_o(pc0), .rf_reset_o(rf0), .running_o(run0), .done_o(dn0),
    .cycle_count_o(cnt0)
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
    , .timeout_o(to0)
`endif
  );

  cpu_reset_ctrl #(.RESET_CYCLES(3), .STAGGER(2)) u_dut1 (
    .clk_i(clk), .sys_reset_i(sr1), .restart_req_i(rq1), .halt_i(h1),
    .pc_reset_o(pc1), .rf_reset_o(rf1), .running_o(run1), .done_o(dn1),
    .cycle_count_o(cnt1)
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
    , .timeout_o(to1)
`endif
  );

  cpu_reset_ctrl #(.CNT_W(4), .RUN_CYCLES(100)) u_dut2 (
    .clk_i(clk), .sys_reset_i(sr2), .restart_req_i(rq2), .halt_i(h2),
    .pc_reset_o(pc2), .rf_reset_o(rf2), .running_o(run2), .done_o(dn2),
    .cycle_count_o(cnt2)
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
    , .timeout_o(to2)
`endif
  );

  typedef struct {
    logic        sr, rq, h;
    logic        pc, rf, run, dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic sr, input logic rq, input logic h,
                              input logic pc, input logic rf, input logic run,
                              input logic dn, input int cnt);
    vec_t v;
    v.sr = sr; v.rq = rq; v.h = h;
    v.pc = pc; v.rf = rf; v.run = run; v.dn = dn;
    v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // {pc, rf, running, done} packed for compact comparisons
  function automatic logic [3:0] st0();
    return {pc0, rf0, run0, dn0};
  endfunction
  function automatic logic [3:0] st1();
    return {pc1, rf1, run1, dn1};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //            sr rq h   pc rf run dn cnt
    tbl[0]  = mk(1, 0, 0,  1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0,  1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0,  0, 0, 1, 0, 1);
    tbl[4]  = mk(0, 0, 0,  0, 0, 1, 0, 2);
    tbl[5]  = mk(0, 0, 1,  0, 0, 0, 1, 2);
    tbl[6]  = mk(0, 0, 1,  0, 0, 0, 1, 2);
    tbl[7]  = mk(0, 1, 0,  1, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0,  0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0,  0, 0, 1, 0, 1);
    tbl[10] = mk(0, 1, 1,  1, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 1,  0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 0,  0, 0, 1, 0, 1);
    tbl[13] = mk(1, 1, 1,  1, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,  0, 0, 1, 0, 0);
    tbl[15] = mk(0, 0, 0,  0, 0, 1, 0, 1);
    tbl[16] = mk(0, 0, 0,  0, 0, 1, 0, 2);
    tbl[17] = mk(0, 0, 0,  0, 0, 1, 0, 3);
    tbl[18] = mk(0, 0, 0,  0, 0, 1, 0, 4);
    tbl[19] = mk(0, 0, 0,  0, 0, 1, 0, 5);
    tbl[20] = mk(0, 1, 1,  1, 1, 0, 0, 0);
    tbl[21] = mk(1, 0, 0,  1, 1, 0, 0, 0);
    tbl[22] = mk(0, 0, 0,  0, 0, 1, 0, 0);
    tbl[23] = mk(0, 0, 1,  0, 0, 0, 1, 0);
    tbl[24] = mk(1, 0, 0,  1, 1, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      sr0 = tbl[i].sr; rq0 = tbl[i].rq; h0 = tbl[i].h;
      tick();
      chk($sformatf("vec%0d_status", i), 32'(st0()),
          32'({tbl[i].pc, tbl[i].rf, tbl[i].run, tbl[i].dn}));
      chk($sformatf("vec%0d_count", i), 32'(cnt0), 32'(tbl[i].cnt));
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
      chk($sformatf("vec%0d_timeout", i), 32'(to0), 32'd0);
`endif
    end

    // Long run on dut0: watchdog expiry, or uninterrupted counting without it
    sr0 = 1'b0; rq0 = 1'b0; h0 = 1'b0;
    tick();
    chk("long_run_entry", 32'({st0(), cnt0}), 32'({4'b0010, 16'd0}));
    repeat (28) tick();
    chk("long_run_c28", 32'({st0(), cnt0}), 32'({4'b0010, 16'd28}));
`ifdef CPU_RESET_CTRL_WATCHDOG_EN
    tick();
    chk("wd_expire", 32'({st0(), to0, cnt0}), 32'({4'b0001, 1'b1, 16'd28}));
    tick();
    chk("wd_hold", 32'({st0(), to0, cnt0}), 32'({4'b0001, 1'b1, 16'd28}));
    rq0 = 1'b1;
    tick();
    chk("wd_restart", 32'({st0(), to0, cnt0}), 32'({4'b1100, 1'b0, 16'd0}));
    rq0 = 1'b0;
    tick();
    repeat (28) tick();
    chk("wd_rerun_c28", 32'({st0(), cnt0}), 32'({4'b0010, 16'd28}));
    h0 = 1'b1;
    tick();
    h0 = 1'b0;
    chk("wd_halt_wins", 32'({st0(), to0, cnt0}), 32'({4'b0001, 1'b0, 16'd28}));
`else
    repeat (12) tick();
    chk("no_wd_c40", 32'({st0(), cnt0}), 32'({4'b0010, 16'd40}));
    h0 = 1'b1;
    tick();
    h0 = 1'b0;
    chk("no_wd_halt", 32'({st0(), cnt0}), 32'({4'b0001, 16'd40}));
`endif

    // dut1: staggered release, restart, sys_reset inside REL_RF
    sr1 = 1'b0;
    tick(); chk("stag_e1", 32'(st1()), 32'b1100);
    tick(); chk("stag_e2", 32'(st1()), 32'b1100);
    tick(); chk("stag_e3_rf_rel", 32'(st1()), 32'b1000);
    tick(); chk("stag_e4", 32'(st1()), 32'b1000);
    tick(); chk("stag_e5_pc_rel", 32'({st1(), cnt1}), 32'({4'b0010, 16'd0}));
    tick(); chk("stag_run_c1", 32'({st1(), cnt1}), 32'({4'b0010, 16'd1}));
    rq1 = 1'b1;
    tick(); chk("stag_restart", 32'({st1(), cnt1}), 32'({4'b1100, 16'd0}));
    rq1 = 1'b0;
    tick(); tick();
    chk("stag_rehold", 32'(st1()), 32'b1100);
    tick(); chk("stag_rel_rf2", 32'(st1()), 32'b1000);
    sr1 = 1'b1;
    tick(); chk("stag_sr_in_relrf", 32'(st1()), 32'b1100);
    sr1 = 1'b0;
    tick(); tick();
    chk("stag_sr_rehold", 32'(st1()), 32'b1100);
    tick(); chk("stag_rel_rf3", 32'(st1()), 32'b1000);
    rq1 = 1'b1;
    tick(); chk("stag_rq_ignored", 32'(st1()), 32'b1000);
    tick(); chk("stag_run3", 32'({st1(), cnt1}), 32'({4'b0010, 16'd0}));
    rq1 = 1'b0;

    // dut2: 4-bit counter saturates at 15
    sr2 = 1'b0;
    tick();
    chk("sat_entry", 32'({run2, cnt2}), 32'({1'b1, 4'd0}));
    for (int i = 1; i < 20; i++) begin
      tick();
      chk($sformatf("sat_c%0d", i), 32'({run2, cnt2}), 32'({1'b1, 4'((i < 15) ? i : 15)}));
    end
    h2 = 1'b1;
    tick();
    h2 = 1'b0;
    chk("sat_halt", 32'({pc2, rf2, run2, dn2, cnt2}), 32'({4'b0001, 4'd15}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
